transfer_tx: RTL and testbench

TRANSFER_TX -- requirements
Module: transfer_tx

---
 rtl/kv_cmd_pkg.sv | 21 ++
 rtl/transfer_tx.sv | 110 +++++++++++
 tb/tb_transfer_tx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/kv_cmd_pkg.sv
// Definitions shared by the key-value command transmitter and receivers:
// opcodes, frame geometry and the transmitter state type.
package kv_cmd_pkg;

  localparam logic [7:0] OP_GET      = 8'h47;
  localparam logic [7:0] OP_PUT      = 8'h50;
  localparam logic [7:0] OP_TRANSFER = 8'h54;

  localparam int FRAME_LEN = 8;
  localparam int IDX_W     = $clog2(FRAME_LEN);

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(FRAME_LEN - 1);

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/transfer_tx.sv
// Serializes a transfer command into an 8-byte frame:
// opcode, src, dst, amount (MSB first), XOR checksum of the first seven bytes.
module transfer_tx
  import kv_cmd_pkg::*;
#(
  parameter logic [7:0] OPCODE = OP_TRANSFER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_src,
  input  logic [7:0]  cmd_dst,
  input  logic [31:0] cmd_amount,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic [15:0] frame_count,
  output tx_state_e   state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never depends on ready, and a presented byte holds until taken.

  tx_state_e   state_q, state_d;
  idx_t        idx_q, idx_d;
  logic [7:0]  src_q, dst_q, csum_q;
  logic [31:0] amount_q;
  logic [15:0] count_q;
  logic        load, done;
  logic [7:0]  csum_d;

  assign csum_d = OPCODE ^ cmd_src ^ cmd_dst ^ cmd_amount[31:24] ^
                  cmd_amount[23:16] ^ cmd_amount[15:8] ^ cmd_amount[7:0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (cmd_valid) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (byte_ready) begin
          if (idx_q == LAST_IDX) begin
            done    = 1'b1;
            idx_d   = '0;
            state_d = TX_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= TX_IDLE;
      idx_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      amount_q <= '0;
      csum_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        src_q    <= cmd_src;
        dst_q    <= cmd_dst;
        amount_q <= cmd_amount;
        csum_q   <= csum_d;
      end
      if (done) count_q <= count_q + 16'd1;
    end
  end

  // The byte mux reads only captured registers, so inputs may change freely mid-frame.
  always_comb begin
    byte_out = '0;
    if (state_q == TX_SEND) begin
      case (idx_q)
        idx_t'(0): byte_out = OPCODE;
        idx_t'(1): byte_out = src_q;
        idx_t'(2): byte_out = dst_q;
        idx_t'(3): byte_out = amount_q[31:24];
        idx_t'(4): byte_out = amount_q[23:16];
        idx_t'(5): byte_out = amount_q[15:8];
        idx_t'(6): byte_out = amount_q[7:0];
        default:   byte_out = csum_q;
      endcase
    end
  end

  assign cmd_ready   = (state_q == TX_IDLE);
  assign byte_valid  = (state_q == TX_SEND);
  assign busy        = (state_q == TX_SEND);
  assign frame_count = count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_transfer_tx.sv
// Self-checking bench for transfer_tx: queue-based frame model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_transfer_tx;
  import kv_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_src, cmd_dst;
  logic [31:0] cmd_amount;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic [15:0] frame_count;
  tx_state_e   state;

  transfer_tx dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_amount(cmd_amount),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .frame_count(frame_count), .state(state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         hs_cyc_q[$];
  int         model_count = 0;
  bit         hold_pending = 0;
  logic [7:0] hold_byte;
  bit         rst_seen = 0;
  bit         rand_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_frame(input logic [7:0] s, input logic [7:0] d, input logic [31:0] a);
    logic [7:0] f[8];
    logic [7:0] x;
    f[0] = 8'h54; f[1] = s; f[2] = d;
    for (int i = 0; i < 4; i++) f[3+i] = 8'((a >> (24 - 8*i)) & 32'hFF);
    x = 8'h00;
    for (int i = 0; i < 7; i++) x = x ^ f[i];
    f[7] = x;
    for (int i = 0; i < 8; i++) exp_q.push_back(f[i]);
  endfunction

  // Per-cycle compare against the frame model
  always @(negedge clk) begin
    bit idle_model;
    cyc++;
    if (rst) begin
      exp_q.delete();
      model_count  = 0;
      hold_pending = 0;
      rst_seen     = 1;
    end else begin
      idle_model = (exp_q.size() == 0);
      if (rst_seen) begin
        check("after_reset_ready", {31'd0, cmd_ready}, 32'd1);
        rst_seen = 0;
      end
      check("frame_count", {16'd0, frame_count}, {16'd0, model_count[15:0]});
      check("byte_valid", {31'd0, byte_valid}, {31'd0, !idle_model});
      check("busy", {31'd0, busy}, {31'd0, !idle_model});
      check("cmd_ready", {31'd0, cmd_ready}, {31'd0, idle_model});
      check("state", {31'd0, state == TX_SEND}, {31'd0, !idle_model});
      if (!byte_valid) check("idle_byte_out", {24'd0, byte_out}, 32'd0);
      if (hold_pending) check("hold_byte", {24'd0, byte_out}, {24'd0, hold_byte});
      if (byte_valid && !idle_model) check("byte_out", {24'd0, byte_out}, {24'd0, exp_q[0]});
      hold_pending = 0;
      if (byte_valid && byte_ready) begin
        got_q.push_back(byte_out);
        hs_cyc_q.push_back(cyc);
        if (!idle_model) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) model_count++;
        end
      end else if (byte_valid) begin
        hold_pending = 1;
        hold_byte    = byte_out;
      end
      if (cmd_valid && idle_model) push_frame(cmd_src, cmd_dst, cmd_amount);
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 byte_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_cmd(input logic [7:0] s, input logic [7:0] d, input logic [31:0] a);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_src = s; cmd_dst = d; cmd_amount = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) check("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_src    = 8'($urandom);
    cmd_dst    = 8'($urandom);
    cmd_amount = $urandom;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string name, input logic [63:0] lit);
    check({name, "_len"}, got_q.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < got_q.size())
        check(name, {24'd0, got_q[i]}, {24'd0, 8'((lit >> (56 - 8*i)) & 64'hFF)});
  endtask

  initial begin
    bit ok;
    rst = 1'b1; cmd_valid = 1'b0; byte_ready = 1'b0;
    cmd_src = '0; cmd_dst = '0; cmd_amount = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("reset_byte_out", {24'd0, byte_out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_frame_count", {16'd0, frame_count}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    byte_ready = 1'b1;

    // Reset while byte 4 is presented
    send_cmd(8'h01, 8'h02, 32'h0000_0064);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_valid", {31'd0, byte_valid}, 32'd0);
    check("midreset_count", {16'd0, frame_count}, 32'd0);

    // Basic frame
    got_q.delete(); hs_cyc_q.delete();
    send_cmd(8'h01, 8'h02, 32'h0000_0064);
    wait_idle(50);
    check_frame("basic", 64'h5401_0200_0000_6433);
    if (hs_cyc_q.size() == 8) check("basic_span", hs_cyc_q[7] - hs_cyc_q[0], 32'd7);
    check("basic_count", {16'd0, frame_count}, 32'd1);

    // Backpressure on byte 3
    got_q.delete();
    send_cmd(8'h01, 8'h02, 32'h0000_0064);
    repeat (3) @(posedge clk);
    #1 byte_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_byte", {24'd0, byte_out}, 32'h00);
      check("bp_hold_valid", {31'd0, byte_valid}, 32'd1);
    end
    @(posedge clk); #1 byte_ready = 1'b1;
    wait_idle(50);
    check_frame("backpressure", 64'h5401_0200_0000_6433);
    check("bp_count", {16'd0, frame_count}, 32'd2);

    // Back-to-back with cmd_valid held high
    got_q.delete(); hs_cyc_q.delete();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_src = 8'h10; cmd_dst = 8'h20; cmd_amount = 32'h1234_5678;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (got_q.size() >= 16) begin ok = 1; break; end
    end
    cmd_valid = 1'b0;
    if (!ok) check("b2b_timeout", 32'd0, 32'd1);
    wait_idle(50);
    if (hs_cyc_q.size() >= 9) check("b2b_gap", hs_cyc_q[8] - hs_cyc_q[7], 32'd2);
    check("b2b_count", {16'd0, frame_count}, 32'd4);

    // All-ones checksum
    got_q.delete();
    send_cmd(8'hFF, 8'hFF, 32'hFFFF_FFFF);
    wait_idle(50);
    if (got_q.size() == 8) check("allones_csum", {24'd0, got_q[7]}, 32'h54);
    check("allones_count", {16'd0, frame_count}, 32'd5);

    // Randomized traffic with random backpressure and input churn
    rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send_cmd(8'($urandom), 8'($urandom), $urandom);
      wait_idle(400);
    end
    rand_ready = 0;
    @(posedge clk); #1 byte_ready = 1'b1;
    @(negedge clk);
    check("random_count", {16'd0, frame_count}, 32'd45);

    // Counter wrap from 0xFFFF
    @(posedge clk); #2;
    force dut.count_q = 16'hFFFF;
    model_count = 32'hFFFF;
    #1 release dut.count_q;
    send_cmd(8'h01, 8'h02, 32'h0000_0064);
    wait_idle(50);
    check("wrap_count", {16'd0, frame_count}, 32'd0);

    repeat (2) @(negedge clk);
    check("model_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
